// File: rtl/roster_list_scanner.sv
// Host-side list-mode reader for the lobby roster: walks one team's slot list,
// collects distinct non-zero IDs in order of first appearance, and checks the count against numPly.
module roster_list_scanner #(
  parameter int N_SLOTS  = 5,
  parameter int ID_W     = 4,
  parameter int SCAN_LEN = N_SLOTS + 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         start,
  input  logic                         team_sel,
  input  logic [ID_W-1:0]              listOut_in,
  input  logic                         listMode_in,
  input  logic [7:0]                   numPly_in,
  output logic [ID_W-1:0]              userID_out,
  output logic                         team_out,
  output logic [1:0]                   mode_out,
  output logic                         busy,
  output logic                         done,
  output logic                         snap_valid,
  output logic [$clog2(N_SLOTS+1)-1:0] snap_cnt,
  output logic [N_SLOTS*ID_W-1:0]      snap_ids,
  output logic                         mismatch,
  output logic                         proto_err
);

  localparam int CNT_W = $clog2(N_SLOTS + 1);
  localparam int ISS_W = $clog2(SCAN_LEN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Find with ID 0 is the only side-effect-free idle command for the roster.
  localparam logic [1:0] MODE_FIND = 2'b10;
  localparam logic [1:0] MODE_LIST = 2'b11;

  logic [1:0]              state_q, state_d;
  logic [ISS_W-1:0]        issue_q, issue_d;
  logic [1:0]              mode_q, mode_d;
  logic                    team_q, team_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_SLOTS*ID_W-1:0] ids_q, ids_d;
  logic                    mis_q, mis_d;
  logic                    perr_q, perr_d;
  logic                    start_prev_q, start_prev_d;
  logic                    hit;
  logic                    sample_en;

  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    mode_d       = mode_q;
    team_d       = team_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    ids_d        = ids_q;
    mis_d        = mis_q;
    perr_d       = perr_q;
    start_prev_d = start;
    hit          = 1'b0;

    for (int k = 0; k < N_SLOTS; k++) begin
      if ((CNT_W'(k) < cnt_q) && (ids_q[k*ID_W +: ID_W] == listOut_in)) hit = 1'b1;
    end

    // Roster output lags the command by one cycle, so sampling starts on the second list edge.
    sample_en = ((state_q == SCAN) && (issue_q != '0)) || (state_q == DRAIN);

    if (sample_en) begin
      if (!listMode_in) begin
        perr_d = 1'b1;
      end else if ((listOut_in != '0) && !hit && (cnt_q < CNT_W'(N_SLOTS))) begin
        for (int k = 0; k < N_SLOTS; k++) begin
          if (CNT_W'(k) == cnt_q) ids_d[k*ID_W +: ID_W] = listOut_in;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Rising-edge acceptance: a start held high launches exactly one scan.
        if (start && !start_prev_q) begin
          ids_d   = '0;
          cnt_d   = '0;
          mis_d   = 1'b0;
          perr_d  = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          team_d  = team_sel;
          mode_d  = MODE_LIST;
          issue_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        issue_d = issue_q + 1'b1;
        if (issue_q == ISS_W'(SCAN_LEN - 1)) begin
          mode_d  = MODE_FIND;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        valid_d = 1'b1;
        mis_d   = (numPly_in != 8'(cnt_d));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      issue_q      <= '0;
      mode_q       <= MODE_FIND;
      team_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      ids_q        <= '0;
      mis_q        <= 1'b0;
      perr_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      mode_q       <= mode_d;
      team_q       <= team_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      ids_q        <= ids_d;
      mis_q        <= mis_d;
      perr_q       <= perr_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign userID_out = '0;
  assign team_out   = team_q;
  assign mode_out   = mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign snap_valid = valid_q;
  assign snap_cnt   = cnt_q;
  assign snap_ids   = ids_q;
  assign mismatch   = mis_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_roster_list_scanner.sv
// Bench for roster_list_scanner: a small roster list-mode model feeds the DUT,
// and a queue-based reference computes the expected snapshot from slot contents.
module tb_roster_list_scanner;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int SL = N + 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  logic          team_sel;
  logic [W-1:0]  listOut_in;
  logic          listMode_in;
  logic [7:0]    numPly_in;
  logic [W-1:0]  userID_out;
  logic          team_out;
  logic [1:0]    mode_out;
  logic          busy;
  logic          done;
  logic          snap_valid;
  logic [2:0]    snap_cnt;
  logic [N*W-1:0] snap_ids;
  logic          mismatch;
  logic          proto_err;

  int nerr = 0;
  int nchk = 0;

  logic [W-1:0] slots [2][N];
  logic         force_lm0;
  int           ptr;
  logic [W-1:0] lo_r;
  logic         lm_r;

  always #5 CLK = ~CLK;

  roster_list_scanner dut (
    .CLK(CLK), .nRST(nRST), .start(start), .team_sel(team_sel),
    .listOut_in(listOut_in), .listMode_in(listMode_in), .numPly_in(numPly_in),
    .userID_out(userID_out), .team_out(team_out), .mode_out(mode_out),
    .busy(busy), .done(done), .snap_valid(snap_valid), .snap_cnt(snap_cnt),
    .snap_ids(snap_ids), .mismatch(mismatch), .proto_err(proto_err)
  );

  // Roster list mode: walks slots from the top index down, one per list-mode cycle.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= N - 1; lm_r <= 1'b0; lo_r <= '0;
    end else if (mode_out == 2'b11) begin
      lo_r <= slots[team_out][ptr];
      lm_r <= 1'b1;
      ptr  <= (ptr == 0) ? N - 1 : ptr - 1;
    end else begin
      ptr <= N - 1; lm_r <= 1'b0; lo_r <= '0;
    end
  end
  assign listOut_in  = lo_r;
  assign listMode_in = lm_r & ~force_lm0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input bit tm, input bit f0,
                                    output logic [N*W-1:0] ids, output int cnt);
    int q[$];
    ids = '0;
    if (!f0) begin
      for (int s = 0; s < SL; s++) begin
        int v;
        bit seen;
        v = int'(slots[tm][(N - 1) - (s % N)]);
        seen = 0;
        foreach (q[j]) if (q[j] == v) seen = 1;
        if (v != 0 && !seen && q.size() < N) q.push_back(v);
      end
    end
    foreach (q[j]) ids[j*W +: W] = W'(q[j]);
    cnt = q.size();
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(mode_out), 32'h2);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_valid"}, 32'(snap_valid), 32'h0);
    chk({tag, "_cnt"}, 32'(snap_cnt), 32'h0);
    chk({tag, "_ids"}, 32'(snap_ids), 32'h0);
    chk({tag, "_team"}, 32'(team_out), 32'h0);
    chk({tag, "_mis"}, 32'(mismatch), 32'h0);
    chk({tag, "_perr"}, 32'(proto_err), 32'h0);
  endtask

  task automatic run_scan(input string tag, input bit tm, input bit f0, input logic [7:0] np);
    logic [N*W-1:0] eids;
    int ecnt;
    int lat;
    ref_model(tm, f0, eids, ecnt);
    team_sel  = tm;
    force_lm0 = f0;
    numPly_in = np;
    @(negedge CLK) start = 1'b1;
    @(posedge CLK); #1;
    start    = 1'b0;
    team_sel = ~tm;
    chk({tag, "_busy0"}, 32'(busy), 32'h1);
    chk({tag, "_mode0"}, 32'(mode_out), 32'h3);
    chk({tag, "_team"}, 32'(team_out), 32'(tm));
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (done) begin lat = i; break; end
      chk({tag, "_mode"}, 32'(mode_out), (i < SL) ? 32'h3 : 32'h2);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(SL + 1));
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_valid"}, 32'(snap_valid), 32'h1);
    chk({tag, "_cnt"}, 32'(snap_cnt), 32'(ecnt));
    chk({tag, "_ids"}, 32'(snap_ids), 32'(eids));
    chk({tag, "_mis"}, 32'(mismatch), 32'(32'(np) != 32'(ecnt)));
    chk({tag, "_perr"}, 32'(proto_err), 32'(f0));
    chk({tag, "_uid"}, 32'(userID_out), 32'h0);
    @(posedge CLK); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'h0);
    chk({tag, "_valid_hold"}, 32'(snap_valid), 32'h1);
    force_lm0 = 1'b0;
  endtask

  initial begin
    int ndone;
    logic [N*W-1:0] rids;
    int rcnt;
    nRST = 1'b0; start = 1'b0; team_sel = 1'b0; numPly_in = 8'd0; force_lm0 = 1'b0;
    for (int t = 0; t < 2; t++) for (int s = 0; s < N; s++) slots[t][s] = '0;
    #12;
    check_reset_vals("rst");
    @(negedge CLK) nRST = 1'b1;

    // Directed: team 0 slots [4..0] = {3,5,0,7,0}, numPly 3
    slots[0][4] = 4'd3; slots[0][3] = 4'd5; slots[0][2] = 4'd0; slots[0][1] = 4'd7; slots[0][0] = 4'd0;
    run_scan("t2", 1'b0, 1'b0, 8'd3);
    chk("t2_ids_const", 32'(snap_ids), 32'h753);

    // Team 1 empty
    run_scan("t3", 1'b1, 1'b0, 8'd0);

    // All five IDs, numPly 4 then 9
    slots[0][0] = 4'd1; slots[0][1] = 4'd2; slots[0][2] = 4'd3; slots[0][3] = 4'd4; slots[0][4] = 4'd6;
    run_scan("t4a", 1'b0, 1'b0, 8'd4);
    chk("t4a_cnt_const", 32'(snap_cnt), 32'd5);
    run_scan("t4b", 1'b0, 1'b0, 8'd9);

    // listMode forced low
    run_scan("t5", 1'b0, 1'b1, 8'd5);

    // Async reset mid-scan
    team_sel = 1'b1;
    @(negedge CLK) start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK); @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    check_reset_vals("t1");
    @(negedge CLK) nRST = 1'b1;

    // start held high for 10 cycles
    ndone = 0;
    team_sel = 1'b0; numPly_in = 8'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK) start = 1'b1;
      if (done) ndone++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK) start = 1'b0;
      if (done) ndone++;
    end
    chk("t6_done_once", 32'(ndone), 32'd1);
    chk("t6_valid", 32'(snap_valid), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);

    // Reset at the third SCAN cycle, then a clean scan
    @(negedge CLK) start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(snap_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_mode", 32'(mode_out), 32'h2);
    @(negedge CLK) nRST = 1'b1;
    run_scan("t6_post", 1'b0, 1'b0, 8'd5);

    // Randomized scans
    for (int r = 0; r < 10; r++) begin
      bit tm;
      logic [7:0] np;
      for (int t = 0; t < 2; t++)
        for (int s = 0; s < N; s++)
          slots[t][s] = ($urandom_range(0, 2) == 0) ? 4'd0 : W'($urandom_range(1, 15));
      tm = 1'($urandom_range(0, 1));
      ref_model(tm, 1'b0, rids, rcnt);
      np = ($urandom_range(0, 1) == 0) ? 8'(rcnt) : 8'($urandom_range(0, 9));
      run_scan("rnd", tm, ($urandom_range(0, 7) == 0), np);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
